izhikevich_array: RTL
=====================

Name: izhikevich_array

Overview:
- Time-multiplexed Izhikevich neuron engine.
- Holds membrane state (v, u) and per-neuron parameters (a, b, c, d) for NEURONS neurons in internal registers.
- On each step_start it performs one Euler update of every neuron in index order, fetching input current from an external current memory and emitting one spike event per firing neuron.
- It replaces single-neuron instances in the graph accelerator; spike events feed the synapse/graph routing stage.

Parameters:
- WIDTH, 17: signed fixed-point word width.
- FRAC, 8: fractional bits (Q8.8 at default).
- NEURONS, 16: neuron count.
- IDX_W, $clog2(NEURONS): index width.
- DT_SHIFT, 0: Euler step dt = 2^-DT_SHIFT ms.
- VPEAK, 17'sd7680: spike threshold (+30.0).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- step_start  in  1  one-cycle pulse; begin update of all neurons
- busy  out  1  high from the cycle after an accepted step_start until done
- done  out  1  one-cycle pulse when the step completes
- cur_addr  out  IDX_W  current-memory read address
- cur_data  in  WIDTH  input current I (signed); valid the cycle after cur_addr is presented
- spike_valid  out  1  one-cycle pulse; the neuron fired this step
- spike_id  out  IDX_W  index of the firing neuron
- cfg_we  in  1  configuration write strobe
- cfg_addr  in  IDX_W  neuron index to write
- cfg_sel  in  3  target field: 0=a, 1=b, 2=c, 3=d, 4=v, 5=u; 6 and 7 ignored
- cfg_data  in  WIDTH  write value
- mon_addr  in  IDX_W  monitor index
- mon_v  out  WIDTH  v[mon_addr], combinational
- mon_u  out  WIDTH  u[mon_addr], combinational

Behaviour:
- Reset (clk edge with rst=1), applied to every neuron:
  - Parameters and state: a=5 (0.02), b=51 (0.2), c=-16640 (-65), d=2048 (8), v=-16640, u=0.
  - Outputs: busy, done, spike_valid = 0; cur_addr = 0; spike_id = 0; FSM = IDLE.
- Reset mid-step aborts the step with no done pulse.
- FSM states:
  - IDLE: step_start=1 -> idx=0, go to FETCH. step_start while busy is ignored.
  - FETCH: cur_addr=idx; latch v, u, a, b, c, d of idx. Go to COMPUTE.
  - COMPUTE: sample cur_data as I; compute the update and write back v[idx], u[idx] at the clock edge. Fire outputs are registered: spike_valid/spike_id are high in the cycle after COMPUTE. If idx==NEURONS-1 go to DONE, else idx++ and go to FETCH.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: done is asserted exactly 2*NEURONS+2 cycles after the step_start cycle.
- Configuration:
  - cfg_we is honoured only in IDLE with no step_start in the same cycle; otherwise it is dropped. If cfg_we and step_start are both high in IDLE, the step is accepted and the write is dropped.
  - The write takes effect at the clock edge.
- Arithmetic (all signed):
  - mul(x,y) = full 2*WIDTH product, arithmetic shift right by FRAC (floor), truncated to WIDTH+4 bits.
  - dv = mul(mul(K1,v),v) + mul(K5,v) + K140 - u + I, with K1=10, K5=1280, K140=35840. Evaluated in WIDTH+4 bits.
  - v_new = sat(v + (dv >>> DT_SHIFT)).
  - du = mul(a, mul(b,v) - u); u_new = sat(u + (du >>> DT_SHIFT)).
  - sat clips to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Firing:
  - If v_new >= VPEAK (signed compare after saturation): v<=c, u<=sat(u+d), spike_valid=1.
  - Otherwise: v<=v_new, u<=u_new.
- Neurons not yet processed in a step use their previous-step state (no cross-neuron coupling).

Test Plan:
- Reset, step_start with I=0 for all neurons -> after 34 cycles (NEURONS=16) done pulses once; mon_addr=0 gives mon_v=-21750, mon_u=-65; no spike_valid.
- cfg write v[3]=7424 (29.0), then step with cur_data=25600 (100) for idx 3 -> spike_valid with spike_id=3 in the cycle after idx 3's COMPUTE; v[3]=-16640, u[3]=2048; no other spikes.
- cfg v[5]=-25600, u[5]=65280, I[5]=-65280 -> v[5] saturates to -65536; no spike.
- step_start held high for 3 cycles, plus cfg_we pulses during busy -> exactly one step (one done); the cfg writes have no effect, checked via mon_v/mon_u.
- rst asserted at cycle 10 of a step -> next cycle all outputs are 0 and state has reset values; a new step_start completes normally.
- DT_SHIFT=1 build, repeat the first scenario -> mon_v=-19195 (-16640 + (-5110>>>1)), mon_u=-33.

Source files
------------

// File: rtl/izhikevich_array.sv
// Time-multiplexed Izhikevich neuron engine: one Euler step of every neuron per step_start,
// with per-neuron state/parameters held in registers and spikes emitted as index events.
module izhikevich_array #(
  parameter int                      WIDTH    = 17,
  parameter int                      FRAC     = 8,
  parameter int                      NEURONS  = 16,
  parameter int                      IDX_W    = $clog2(NEURONS),
  parameter int                      DT_SHIFT = 0,
  parameter logic signed [WIDTH-1:0] VPEAK    = 17'sd7680
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_start,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        cur_addr,
  input  logic signed [WIDTH-1:0] cur_data,
  output logic                    spike_valid,
  output logic [IDX_W-1:0]        spike_id,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_addr,
  input  logic [2:0]              cfg_sel,
  input  logic signed [WIDTH-1:0] cfg_data,
  input  logic [IDX_W-1:0]        mon_addr,
  output logic signed [WIDTH-1:0] mon_v,
  output logic signed [WIDTH-1:0] mon_u
);

  localparam int EW = WIDTH + 4;

  localparam logic signed [EW-1:0] K1   = EW'(10);
  localparam logic signed [EW-1:0] K5   = EW'(1280);
  localparam logic signed [EW-1:0] K140 = EW'(35840);

  localparam logic signed [WIDTH-1:0] W_MAX = WIDTH'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [WIDTH-1:0] W_MIN = WIDTH'(-(2 ** (WIDTH - 1)));

  localparam logic signed [WIDTH-1:0] A_RST = WIDTH'(5);
  localparam logic signed [WIDTH-1:0] B_RST = WIDTH'(51);
  localparam logic signed [WIDTH-1:0] C_RST = WIDTH'(-16640);
  localparam logic signed [WIDTH-1:0] D_RST = WIDTH'(2048);
  localparam logic signed [WIDTH-1:0] V_RST = WIDTH'(-16640);
  localparam logic signed [WIDTH-1:0] U_RST = WIDTH'(0);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NEURONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMPUTE, S_DONE} state_t;

  state_t state, state_nx;
  logic [IDX_W-1:0] idx;

  logic signed [WIDTH-1:0] v_mem [NEURONS];
  logic signed [WIDTH-1:0] u_mem [NEURONS];
  logic signed [WIDTH-1:0] a_mem [NEURONS];
  logic signed [WIDTH-1:0] b_mem [NEURONS];
  logic signed [WIDTH-1:0] c_mem [NEURONS];
  logic signed [WIDTH-1:0] d_mem [NEURONS];

  logic signed [WIDTH-1:0] v_l, u_l, a_l, b_l, c_l, d_l;

  logic signed [EW-1:0]    v_e, u_e, i_e, dv, bv, du;
  logic signed [WIDTH-1:0] v_new, u_new, u_fire;
  logic                    fire;

  // Fixed-point product: full-width multiply, floor shift by FRAC, truncate to EW bits.
  function automatic logic signed [EW-1:0] mul(input logic signed [EW-1:0] x,
                                               input logic signed [EW-1:0] y);
    logic signed [2*EW-1:0] p;
    p = (2*EW)'(x) * (2*EW)'(y);
    return EW'(p >>> FRAC);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW:0] x);
    if (x > (EW+1)'(W_MAX)) return W_MAX;
    else if (x < (EW+1)'(W_MIN)) return W_MIN;
    else return WIDTH'(x);
  endfunction

  // Handshake: step_start is a one-cycle request taken only in IDLE; busy covers the whole
  // sweep, done pulses once when it completes, and nothing else is accepted meanwhile.
  assign busy     = (state != S_IDLE);
  assign cur_addr = idx;
  assign mon_v    = v_mem[mon_addr];
  assign mon_u    = u_mem[mon_addr];

  always_comb begin
    v_e    = EW'(v_l);
    u_e    = EW'(u_l);
    i_e    = EW'(cur_data);
    dv     = mul(mul(K1, v_e), v_e) + mul(K5, v_e) + K140 - u_e + i_e;
    bv     = mul(EW'(b_l), v_e) - u_e;
    du     = mul(EW'(a_l), bv);
    v_new  = sat((EW+1)'(v_e) + (EW+1)'(dv >>> DT_SHIFT));
    u_new  = sat((EW+1)'(u_e) + (EW+1)'(du >>> DT_SHIFT));
    u_fire = sat((EW+1)'(u_e) + (EW+1)'(EW'(d_l)));
    fire   = (v_new >= VPEAK);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (step_start) state_nx = S_FETCH;
      S_FETCH:   state_nx = S_COMPUTE;
      S_COMPUTE: state_nx = (idx == LAST) ? S_DONE : S_FETCH;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      done        <= 1'b0;
      spike_valid <= 1'b0;
      spike_id    <= '0;
      v_l         <= '0;
      u_l         <= '0;
      a_l         <= '0;
      b_l         <= '0;
      c_l         <= '0;
      d_l         <= '0;
      for (int i = 0; i < NEURONS; i++) begin
        v_mem[i] <= V_RST;
        u_mem[i] <= U_RST;
        a_mem[i] <= A_RST;
        b_mem[i] <= B_RST;
        c_mem[i] <= C_RST;
        d_mem[i] <= D_RST;
      end
    end else begin
      state       <= state_nx;
      done        <= (state == S_DONE);
      spike_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // A step request wins over a same-cycle configuration write.
          if (step_start) begin
            idx <= '0;
          end else if (cfg_we) begin
            case (cfg_sel)
              3'd0:    a_mem[cfg_addr] <= cfg_data;
              3'd1:    b_mem[cfg_addr] <= cfg_data;
              3'd2:    c_mem[cfg_addr] <= cfg_data;
              3'd3:    d_mem[cfg_addr] <= cfg_data;
              3'd4:    v_mem[cfg_addr] <= cfg_data;
              3'd5:    u_mem[cfg_addr] <= cfg_data;
              default: ;
            endcase
          end
        end
        S_FETCH: begin
          v_l <= v_mem[idx];
          u_l <= u_mem[idx];
          a_l <= a_mem[idx];
          b_l <= b_mem[idx];
          c_l <= c_mem[idx];
          d_l <= d_mem[idx];
        end
        S_COMPUTE: begin
          if (fire) begin
            v_mem[idx]  <= c_l;
            u_mem[idx]  <= u_fire;
            spike_valid <= 1'b1;
            spike_id    <= idx;
          end else begin
            v_mem[idx] <= v_new;
            u_mem[idx] <= u_new;
          end
          if (idx != LAST) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
